// File: rtl/decoder_arbiter_if.sv
// Requester/decoder-side bundle for decoder_arbiter: level requests in, registered select/enable/grant out.
interface decoder_arbiter_if;
    logic [0:15] req;
    logic        done;
    logic [3:0]  sel;
    logic        enable;
    logic [0:15] grant_n;
    logic        busy;
    logic        preempt;

    modport master (
        output req, done,
        input  sel, enable, grant_n, busy, preempt
    );

    modport slave (
        input  req, done,
        output sel, enable, grant_n, busy, preempt
    );
endinterface

// File: rtl/decoder_arbiter.sv
// Round-robin owner sequencer for the shared 4-to-16 active-low decoder; grant one edge after req, bounded hold, one guard cycle.
// No backpressure: requests are levels, non-owners simply stay pending; all outputs registered.
module decoder_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input logic              clk,
    input logic              reset,
    decoder_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

    state_t      state, state_n;
    logic [3:0]  last, last_n;
    logic [3:0]  sel_q, sel_n;
    logic        enable_q, enable_n;
    logic [0:15] grant_n_q, grant_n_n;
    logic        busy_q, busy_n;
    logic        preempt_q, preempt_n;
    logic [CW-1:0] count, count_n;

    logic       found;
    logic [3:0] winner;
    logic       timeout;
    logic       withdraw;

    // Scan from farthest to nearest so the nearest requester after `last` wins.
    always_comb begin
        found  = 1'b0;
        winner = last;
        for (int k = 16; k >= 1; k--) begin
            if (bus.req[4'(last + 4'(k))]) begin
                found  = 1'b1;
                winner = 4'(last + 4'(k));
            end
        end
    end

    always_comb begin
        state_n   = state;
        last_n    = last;
        sel_n     = sel_q;
        enable_n  = enable_q;
        grant_n_n = grant_n_q;
        busy_n    = busy_q;
        preempt_n = 1'b0;
        count_n   = count;
        timeout   = (count == CW'(MAX_HOLD));
        withdraw  = !bus.req[sel_q];

        case (state)
            IDLE, GUARD: begin
                if (found) begin
                    state_n           = GRANT;
                    sel_n             = winner;
                    last_n            = winner;
                    enable_n          = 1'b0;
                    busy_n            = 1'b1;
                    grant_n_n         = '1;
                    grant_n_n[winner] = 1'b0;
                    count_n           = CW'(1);
                end else begin
                    state_n   = IDLE;
                    enable_n  = 1'b1;
                    busy_n    = 1'b0;
                    grant_n_n = '1;
                    count_n   = '0;
                end
            end
            GRANT: begin
                if (bus.done || withdraw || timeout) begin
                    state_n   = GUARD;
                    enable_n  = 1'b1;
                    busy_n    = 1'b0;
                    grant_n_n = '1;
                    count_n   = '0;
                    // Only a pure timeout counts as a preemption.
                    preempt_n = timeout && !bus.done && !withdraw;
                end else begin
                    count_n = count + CW'(1);
                end
            end
            default: begin
                state_n   = IDLE;
                enable_n  = 1'b1;
                busy_n    = 1'b0;
                grant_n_n = '1;
                count_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 4'd15;
            sel_q     <= 4'd0;
            enable_q  <= 1'b1;
            grant_n_q <= '1;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            count     <= '0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            sel_q     <= sel_n;
            enable_q  <= enable_n;
            grant_n_q <= grant_n_n;
            busy_q    <= busy_n;
            preempt_q <= preempt_n;
            count     <= count_n;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.enable  = enable_q;
    assign bus.grant_n = grant_n_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = preempt_q;
endmodule

// File: tb/tb_decoder_arbiter.sv
// Directed bench for decoder_arbiter with MAX_HOLD=8.
module tb_decoder_arbiter;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    decoder_arbiter_if bus();

    decoder_arbiter #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Gate-level reference of the active-low 4-to-16 decoder.
    function automatic logic [0:15] dec(input logic [3:0] s, input logic en);
        logic [0:15] d;
        d = '1;
        if (!en) d[s] = 1'b0;
        return d;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset   = 1'b1;
        bus.req = '0;
        bus.done = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] owner);
        check({tag, "_enable"}, 32'(bus.enable), 32'd0);
        check({tag, "_sel"}, 32'(bus.sel), 32'(owner));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_grant_n"}, 32'(bus.grant_n), 32'(dec(owner, 1'b0)));
    endtask

    task automatic expect_free(input string tag, input logic pre);
        check({tag, "_enable"}, 32'(bus.enable), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_grant_n"}, 32'(bus.grant_n), 32'hFFFF);
        check({tag, "_preempt"}, 32'(bus.preempt), 32'(pre));
    endtask

    initial begin
        logic [0:15] r;

        reset    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_sel", 32'(bus.sel), 32'd0);
        expect_free("rst", 1'b0);

        // Asynchronous reset during a grant.
        do_reset();
        r = '0; r[11] = 1'b1;
        bus.req = r;
        step();
        expect_grant("pre_arst", 4'd11);
        #2 reset = 1'b1;
        #1;
        check("arst_sel", 32'(bus.sel), 32'd0);
        expect_free("arst", 1'b0);
        r[0] = 1'b1;
        bus.req = r;
        #1 reset = 1'b0;
        step();
        expect_grant("arst_first", 4'd0);

        // Single requester: literal 16'h0008 is index 12; done in 3rd cycle.
        do_reset();
        bus.req = 16'h0008;
        step();
        expect_grant("single_c1", 4'd12);
        step();
        expect_grant("single_c2", 4'd12);
        step();
        expect_grant("single_c3", 4'd12);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        expect_free("single_guard", 1'b0);
        step();
        expect_grant("single_regrant", 4'd12);

        // Round-robin with done every grant cycle.
        do_reset();
        bus.req  = 16'hFFFF;
        bus.done = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step();
            expect_grant($sformatf("rr%0d", k), 4'(k % 16));
            step();
            expect_free($sformatf("rr%0d_guard", k), 1'b0);
        end
        bus.done = 1'b0;

        // Timeout: owner 5 holds, 9 waiting.
        do_reset();
        r = '0; r[5] = 1'b1; r[9] = 1'b1;
        bus.req = r;
        for (int i = 1; i <= 8; i++) begin
            step();
            expect_grant($sformatf("to_c%0d", i), 4'd5);
            check($sformatf("to_c%0d_preempt", i), 32'(bus.preempt), 32'd0);
        end
        step();
        expect_free("to_release", 1'b1);
        step();
        expect_grant("to_next", 4'd9);
        check("to_next_preempt", 32'(bus.preempt), 32'd0);

        // Timeout coinciding with done: no preempt.
        do_reset();
        r = '0; r[5] = 1'b1;
        bus.req = r;
        for (int i = 1; i <= 8; i++) step();
        expect_grant("coll_c8", 4'd5);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        expect_free("coll_release", 1'b0);

        // Withdrawal: owner 3 drops mid-grant, 7 pending.
        do_reset();
        r = '0; r[3] = 1'b1; r[7] = 1'b1;
        bus.req = r;
        step();
        expect_grant("wd_c1", 4'd3);
        step();
        expect_grant("wd_c2", 4'd3);
        r[3] = 1'b0;
        bus.req = r;
        step();
        expect_free("wd_guard", 1'b0);
        step();
        expect_grant("wd_next", 4'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
